// File: rtl/window_3x3_ctrl_pkg.sv
// Shared types and constants for the 3x3 window controller.
// Holds the 2-bit FSM encoding and the coordinate counter width.
package window_3x3_ctrl_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that keeps a bundle of sync and coordinate
// bits aligned with the 3x3 window register output.
module sync_delay_line #(
  parameter int W   = 1,
  parameter int DLY = 2
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DLY == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [W-1:0] taps [DLY];

      // NOTE: the tap array is a few flops rather than a RAM, so it is reset
      // and the window outputs read 0 straight out of reset.
      always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DLY; i++) taps[i] <= '0;
        end else begin
          taps[0] <= d;
          for (int i = 1; i < DLY; i++) taps[i] <= taps[i-1];
        end
      end

      assign q = taps[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/window_3x3_ctrl.sv
// Control for a 3x3 pixel window fed by a two-line shift RAM: gates the RAM
// strobes, tracks pixel coordinates and frame state, flags bad line lengths.
module window_3x3_ctrl
  import window_3x3_ctrl_pkg::*;
#(
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int PIPE_DLY = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  output logic             ram_clken,
  output logic             ram_href,
  output logic             win_vsync,
  output logic             win_href,
  output logic             win_clken,
  output logic             win_valid,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             len_err,
  output logic             frame_done
);

  localparam int LW = CNT_W + 1;
  localparam int DW = 3 + 2 * CNT_W;
  localparam logic [CNT_W-1:0] COL_MAX  = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] ROW_MAX  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [LW-1:0]    LINE_LEN = LW'(H_ACT);
  localparam logic [LW-1:0]    LINE_SAT = LW'(H_ACT + 1);

  state_t           state, state_nxt;
  logic             vsync_q, href_q;
  logic [CNT_W-1:0] col_q, col_nxt;
  logic [CNT_W-1:0] row_q, row_nxt;
  logic [LW-1:0]    line_q, line_nxt;
  logic             len_err_nxt, frame_done_nxt;
  logic             run, vsync_rise, href_fall, pix_stb;
  logic [DW-1:0]    dly_in, dly_out;

  // DONE is treated like IDLE here so a finished frame cannot touch the RAM.
  assign run        = (state == FILL) || (state == ACTIVE);
  assign vsync_rise = per_frame_vsync & ~vsync_q;
  assign href_fall  = ~per_frame_href & href_q;
  assign pix_stb    = per_frame_clken & per_frame_href & run;

  assign ram_clken = pix_stb;
  assign ram_href  = per_frame_href & run;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      line_q     <= '0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vsync_q    <= per_frame_vsync;
      href_q     <= per_frame_href;
      col_q      <= col_nxt;
      row_q      <= row_nxt;
      line_q     <= line_nxt;
      len_err    <= len_err_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // NOTE: every output of a comb block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    col_nxt     = col_q;
    row_nxt     = row_q;
    line_nxt    = line_q;
    len_err_nxt = len_err;

    if (pix_stb) begin
      if (col_q != COL_MAX)   col_nxt  = col_q + 1'b1;
      if (line_q != LINE_SAT) line_nxt = line_q + 1'b1;
    end

    // Closing the line looks at the count including any strobe this cycle.
    if (run && href_fall) begin
      if (line_nxt != LINE_LEN) len_err_nxt = 1'b1;
      if (line_nxt != '0 && row_q != ROW_MAX) row_nxt = row_q + 1'b1;
      col_nxt  = '0;
      line_nxt = '0;
    end

    if (vsync_rise) begin
      col_nxt     = '0;
      row_nxt     = '0;
      line_nxt    = '0;
      len_err_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (vsync_rise) state_nxt = FILL;
      end
      FILL: begin
        if (vsync_rise)          state_nxt = FILL;
        else if (row_nxt >= TWO) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (vsync_rise) begin
          state_nxt = FILL;
        end else if (row_nxt == ROW_MAX) begin
          state_nxt      = DONE;
          frame_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinates are sampled before the increment, i.e. the index of the
  // pixel being strobed, then travel with the raw sync signals.
  assign dly_in = {per_frame_vsync, per_frame_href, per_frame_clken, row_q, col_q};

  sync_delay_line #(
    .W   (DW),
    .DLY (PIPE_DLY)
  ) u_sync_dly (
    .clock (clock),
    .rst_n (rst_n),
    .d     (dly_in),
    .q     (dly_out)
  );

  assign {win_vsync, win_href, win_clken, row_cnt, col_cnt} = dly_out;

  assign win_valid = win_clken & (row_cnt >= TWO) & (col_cnt >= TWO);

endmodule

// File: tb/tb_window_3x3_ctrl.sv
// Directed bench for window_3x3_ctrl with an 8x4 frame and a 2-cycle window pipe.
module tb_window_3x3_ctrl;
  import window_3x3_ctrl_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 2;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href  = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic       ram_clken, ram_href, win_vsync, win_href, win_clken, win_valid;
  logic [9:0] col_cnt, row_cnt;
  logic       len_err, frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wv_total = 0;
  int wv_bad = 0;
  int fd_cnt = 0;
  bit exp_v[int];

  window_3x3_ctrl #(.H_ACT(H), .V_ACT(V), .PIPE_DLY(D)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_frame_clken (per_frame_clken),
    .ram_clken       (ram_clken),
    .ram_href        (ram_href),
    .win_vsync       (win_vsync),
    .win_href        (win_href),
    .win_clken       (win_clken),
    .win_valid       (win_valid),
    .col_cnt         (col_cnt),
    .row_cnt         (row_cnt),
    .len_err         (len_err),
    .frame_done      (frame_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // win_valid must be high exactly in the cycles the stimulus marked.
  always @(negedge clock) begin
    bit e;
    if (rst_n) begin
      e = (exp_v.exists(cyc) != 0);
      if (win_valid !== e) wv_bad++;
      if (win_valid === 1'b1) wv_total++;
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_pulse();
    per_frame_vsync = 1'b1;
    tick();
    per_frame_vsync = 1'b0;
    tick();
  endtask

  // row < 0 means no window is expected from this line.
  task automatic send_line(input int n, input int row, output int nr);
    nr = 0;
    for (int k = 0; k < n; k++) begin
      per_frame_href  = 1'b1;
      per_frame_clken = 1'b1;
      #1;
      if (ram_clken === 1'b1) nr++;
      if (row >= 2 && k >= 2) exp_v[cyc + 2] = 1'b1;
      tick();
    end
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    #12;
    checks++; if (ram_clken !== 1'b0) begin errors++; $display("FAIL reset_ram_clken: got %0b want 0", ram_clken); end
    checks++; if (ram_href !== 1'b0) begin errors++; $display("FAIL reset_ram_href: got %0b want 0", ram_href); end
    checks++; if ({win_vsync, win_href, win_clken, win_valid} !== 4'b0) begin errors++; $display("FAIL reset_win: got %b want 0000", {win_vsync, win_href, win_clken, win_valid}); end
    checks++; if ({col_cnt, row_cnt} !== 20'd0) begin errors++; $display("FAIL reset_cnt: got col %0d row %0d want 0 0", col_cnt, row_cnt); end
    checks++; if ({len_err, frame_done} !== 2'b0) begin errors++; $display("FAIL reset_flags: got %b want 00", {len_err, frame_done}); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    per_frame_href = 1'b1; per_frame_clken = 1'b1; #1;
    checks++; if (ram_clken !== 1'b0) begin errors++; $display("FAIL idle_ram_clken: got %0b want 0", ram_clken); end
    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    idle(2);
  endtask

  task automatic test_full_frame();
    int nr, wv0, fd0;
    wv0 = wv_total; fd0 = fd_cnt;
    vsync_pulse();
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL ff_fill: got %0d want %0d", dut.state, FILL); end
    send_line(H, 0, nr);
    checks++; if (nr != H) begin errors++; $display("FAIL ff_ram_strobes: got %0d want %0d", nr, H); end
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL ff_line1_state: got %0d want %0d", dut.state, FILL); end
    idle(2);
    send_line(H, 1, nr);
    checks++; if (dut.state !== ACTIVE) begin errors++; $display("FAIL ff_active: got %0d want %0d", dut.state, ACTIVE); end
    idle(2);
    send_line(H, 2, nr);
    idle(2);
    send_line(H, 3, nr);
    checks++; if (dut.state !== DONE || frame_done !== 1'b1) begin errors++; $display("FAIL ff_done: got state %0d done %0b want %0d 1", dut.state, frame_done, DONE); end
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ff_done_pulse: got %0b want 0", frame_done); end
    idle(4);
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL ff_len_err: got %0b want 0", len_err); end
    checks++; if (wv_total - wv0 != 12) begin errors++; $display("FAIL ff_win_valid_count: got %0d want 12", wv_total - wv0); end
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL ff_done_count: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_ignored_done();
    int nr, fd0;
    fd0 = fd_cnt;
    send_line(3, -1, nr);
    checks++; if (nr != 0) begin errors++; $display("FAIL done_ram_clken: got %0d strobes want 0", nr); end
    for (int k = 0; k < 3; k++) begin per_frame_clken = 1'b1; tick(); end
    per_frame_clken = 1'b0;
    idle(3);
    checks++; if (row_cnt !== 10'd4 || col_cnt !== 10'd0) begin errors++; $display("FAIL done_cnt: got row %0d col %0d want 4 0", row_cnt, col_cnt); end
    checks++; if (dut.state !== DONE) begin errors++; $display("FAIL done_state: got %0d want %0d", dut.state, DONE); end
    checks++; if (len_err !== 1'b0 || fd_cnt != fd0) begin errors++; $display("FAIL done_flags: got len_err %0b pulses %0d want 0 0", len_err, fd_cnt - fd0); end
  endtask

  task automatic test_len_err();
    int nr;
    vsync_pulse();
    checks++; if (dut.state !== FILL || len_err !== 1'b0) begin errors++; $display("FAIL le_start: got state %0d len_err %0b want %0d 0", dut.state, len_err, FILL); end
    for (int k = 0; k < 3; k++) begin
      per_frame_clken = 1'b1; #1;
      checks++; if (ram_clken !== 1'b0) begin errors++; $display("FAIL le_clken_no_href: got %0b want 0", ram_clken); end
      tick();
    end
    per_frame_clken = 1'b0;
    send_line(H, 0, nr);
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL le_full_line: got %0b want 0", len_err); end
    idle(2);
    send_line(H - 1, 1, nr);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL le_short_line: got %0b want 1", len_err); end
    idle(2);
    send_line(H, 2, nr);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL le_sticky: got %0b want 1", len_err); end
    idle(3);
    per_frame_vsync = 1'b1;
    tick();
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL le_clear: got %0b want 0", len_err); end
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic test_short_frame();
    int nr, fd0;
    fd0 = fd_cnt;
    send_line(H, 0, nr);
    idle(2);
    send_line(H, 1, nr);
    idle(3);
    checks++; if (dut.state !== ACTIVE || row_cnt !== 10'd2) begin errors++; $display("FAIL sf_before: got state %0d row %0d want %0d 2", dut.state, row_cnt, ACTIVE); end
    vsync_pulse();
    idle(3);
    checks++; if (dut.state !== FILL || row_cnt !== 10'd0) begin errors++; $display("FAIL sf_restart: got state %0d row %0d want %0d 0", dut.state, row_cnt, FILL); end
    checks++; if (fd_cnt != fd0) begin errors++; $display("FAIL sf_no_done: got %0d pulses want 0", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid_frame();
    int nr;
    send_line(H, 0, nr);
    idle(2);
    send_line(H - 1, 1, nr);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL rm_len_err_pre: got %0b want 1", len_err); end
    idle(2);
    for (int k = 0; k < 2; k++) begin per_frame_href = 1'b1; per_frame_clken = 1'b1; tick(); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({ram_clken, ram_href, win_vsync, win_href, win_clken, win_valid} !== 6'b0) begin errors++; $display("FAIL rm_async_sync: got %b want 000000", {ram_clken, ram_href, win_vsync, win_href, win_clken, win_valid}); end
    checks++; if ({col_cnt, row_cnt} !== 20'd0 || {len_err, frame_done} !== 2'b0) begin errors++; $display("FAIL rm_async_state: got col %0d row %0d flags %b want 0 0 00", col_cnt, row_cnt, {len_err, frame_done}); end
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    nr = 0;
    for (int k = 0; k < 5; k++) begin
      per_frame_href = 1'b1; per_frame_clken = 1'b1; #1;
      if (ram_clken === 1'b1) nr++;
      tick();
    end
    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    tick();
    checks++; if (nr != 0) begin errors++; $display("FAIL rm_rest_of_line: got %0d strobes want 0", nr); end
    idle(2);
    send_line(H, -1, nr);
    checks++; if (nr != 0 || dut.state !== IDLE) begin errors++; $display("FAIL rm_next_line: got %0d strobes state %0d want 0 %0d", nr, dut.state, IDLE); end
    idle(2);
    vsync_pulse();
    send_line(H, 0, nr);
    checks++; if (nr != H || dut.state !== FILL || len_err !== 1'b0) begin errors++; $display("FAIL rm_recover: got %0d strobes state %0d len_err %0b want %0d %0d 0", nr, dut.state, len_err, H, FILL); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_ignored_done();
    test_len_err();
    test_short_frame();
    test_reset_mid_frame();
    checks++; if (wv_bad != 0) begin errors++; $display("FAIL win_valid_timing: got %0d wrong cycles want 0", wv_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
